// File: rtl/dmem_responder.sv
// Data-memory responder: serves cache block refills as fixed-latency bursts
// and absorbs write-through stores, buffering them while a refill is running.
module dmem_responder #(
  parameter int MEM_WORDS   = 1024,
  parameter int BLOCK_WORDS = 4,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_last,
  input  logic        wr_en,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data,
  output logic        wr_ready
);

  localparam int IDX_W  = $clog2(MEM_WORDS);
  localparam int BEAT_W = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
  localparam logic [IDX_W-1:0]  BLK_MASK  = ~IDX_W'(BLOCK_WORDS - 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BLOCK_WORDS - 1);
  localparam logic [2:0]        WAIT_LAST = (LATENCY > 0) ? 3'(LATENCY - 1) : 3'd0;

  typedef enum logic [1:0] {IDLE, WAIT, BURST} state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  base_q, base_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [2:0]        wait_q, wait_d;

  logic [31:0]       mem [MEM_WORDS];
  logic [IDX_W-1:0]  wb_addr_q [2];
  logic [31:0]       wb_data_q [2];
  logic              wb_wptr_q, wb_rptr_q;
  logic [1:0]        wb_cnt_q;

  logic              rsp_valid_q, rsp_last_q;
  logic [31:0]       rsp_data_q;

  logic [IDX_W-1:0]  req_idx, wr_idx, rd_idx, mem_waddr;
  logic [31:0]       rd_word, mem_wdata;
  logic              req_fire, wr_fire, wr_direct, wb_enq, wb_deq, wb_empty, mem_we;
  logic              unused_addr_bits;

  assign req_idx = req_addr[IDX_W+1:2];
  assign wr_idx  = wr_addr[IDX_W+1:2];
  assign unused_addr_bits = ^{req_addr[31:IDX_W+2], req_addr[1:0],
                              wr_addr[31:IDX_W+2], wr_addr[1:0]};

  // State register
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of block order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      base_q  <= '0;
      beat_q  <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      beat_q  <= beat_d;
      wait_q  <= wait_d;
    end
  end

  // Next-state logic
  // NOTE: every always_comb output gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    beat_d  = beat_q;
    wait_d  = wait_q;
    unique case (state_q)
      IDLE: if (req_fire) begin
        base_d  = req_idx & BLK_MASK;
        beat_d  = '0;
        wait_d  = '0;
        state_d = (LATENCY > 0) ? WAIT : BURST;
      end
      WAIT: if (wait_q == WAIT_LAST) state_d = BURST;
            else                     wait_d  = wait_q + 3'd1;
      BURST: if (beat_q == BEAT_LAST) state_d = IDLE;
             else                     beat_d  = beat_q + BEAT_W'(1);
      default: state_d = IDLE;
    endcase
  end

  // Output / handshake decode
  always_comb begin
    wb_empty  = (wb_cnt_q == 2'd0);
    req_ready = (state_q == IDLE) && wb_empty;
    wr_ready  = (wb_cnt_q != 2'd2);
    req_fire  = req_valid && req_ready;
    wr_fire   = wr_en && wr_ready;
    wr_direct = wr_fire && (state_q == IDLE) && wb_empty;
    wb_enq    = wr_fire && !wr_direct;
    wb_deq    = (state_q == IDLE) && !wb_empty;
    mem_we    = rst && (wr_direct || wb_deq);
    mem_waddr = wr_direct ? wr_idx  : wb_addr_q[wb_rptr_q];
    mem_wdata = wr_direct ? wr_data : wb_data_q[wb_rptr_q];
  end

  // A store committing on the same edge as the read must be seen by the burst.
  assign rd_idx  = base_d + IDX_W'(beat_d);
  assign rd_word = (wr_direct && (wr_idx == rd_idx)) ? wr_data : mem[rd_idx];

  // NOTE: storage arrays carry no reset; only their control state is cleared.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    if (wb_enq) begin
      wb_addr_q[wb_wptr_q] <= wr_idx;
      wb_data_q[wb_wptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_wptr_q <= 1'b0;
      wb_rptr_q <= 1'b0;
      wb_cnt_q  <= 2'd0;
    end else begin
      if (wb_enq) wb_wptr_q <= ~wb_wptr_q;
      if (wb_deq) wb_rptr_q <= ~wb_rptr_q;
      wb_cnt_q <= wb_cnt_q + {1'b0, wb_enq} - {1'b0, wb_deq};
    end
  end

  // Beats are registered so they line up with the BURST state cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid_q <= 1'b0;
      rsp_last_q  <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= (state_d == BURST);
      rsp_last_q  <= (state_d == BURST) && (beat_d == BEAT_LAST);
      if (state_d == BURST) rsp_data_q <= rd_word;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_last  = rsp_last_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter MEM_WORDS, default 1024, data array depth in 32-bit words (4 KB, byte address bits [11:2]).
REQ-002 Parameter BLOCK_WORDS, default 4, words per refill burst (16-byte block).
REQ-003 Parameter LATENCY, default 2, wait cycles between request acceptance and first beat (legal 0..7).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 req_valid  input  1  cache requests a block refill.
REQ-007 req_addr  input  32  refill byte address; only bits [11:4] are used.
REQ-008 req_ready  output  1  responder can accept a refill request this cycle.
REQ-009 rsp_valid  output  1  rsp_data holds a valid refill word this cycle.
REQ-010 rsp_data  output  32  refill word, beats in ascending word order.
REQ-011 rsp_last  output  1  marks the final beat of a burst.
REQ-012 wr_en  input  1  write-through store from the cache.
REQ-013 wr_addr  input  32  store byte address; only bits [11:2] are used.
REQ-014 wr_data  input  32  store word.
REQ-015 wr_ready  output  1  store is accepted this cycle.

Function
REQ-016 States SHALL be IDLE, WAIT and BURST, with a 2-entry write buffer (FIFO) alongside.
REQ-017 req_ready SHALL equal (state==IDLE && write buffer empty), combinationally.
REQ-018 In IDLE, req_valid && req_ready SHALL latch base = {req_addr[11:4], 2'b00} (word index) and clear the beat counter; next state is WAIT when LATENCY>0, otherwise BURST.
REQ-019 WAIT SHALL last exactly LATENCY cycles, then go to BURST.
REQ-020 BURST SHALL last BLOCK_WORDS cycles; beat k SHALL drive registered rsp_valid=1, rsp_data=mem[base+k], and rsp_last=(k==BLOCK_WORDS-1); after the last beat the state SHALL return to IDLE.
REQ-021 Outside BURST, rsp_valid and rsp_last SHALL be 0 and rsp_data SHALL hold its last value.
REQ-022 First beat SHALL appear LATENCY+1 cycles after the accepting edge; a back-to-back request can be accepted on the cycle after rsp_last.
REQ-023 wr_ready SHALL be 0 only when the write buffer is full.
REQ-024 A write in IDLE with an empty buffer SHALL commit to mem[wr_addr[11:2]] at that edge.
REQ-025 A write in WAIT or BURST, or in IDLE with a non-empty buffer, SHALL enqueue.
REQ-026 In IDLE the buffer SHALL drain one entry per cycle, oldest first; simultaneous enqueue and dequeue SHALL be allowed.
REQ-027 The buffer SHALL NOT drain during WAIT or BURST.
REQ-028 A write and an accepted request on the same IDLE edge SHALL both proceed; the burst SHALL return the newly written word.
REQ-029 req_valid outside IDLE SHALL be ignored and not queued; the requester holds it until req_ready.
REQ-030 Address bits above [11] and below [2] SHALL be ignored; word index arithmetic SHALL wrap modulo MEM_WORDS.

Reset
REQ-031 rst low SHALL immediately force: state IDLE, rsp_valid=0, rsp_last=0, rsp_data=0, beat counter=0, write buffer empty.
REQ-032 Memory contents SHALL NOT be cleared by reset.
REQ-033 Reset during WAIT or BURST SHALL abort the burst with no further beats, and SHALL discard buffered writes.
REQ-034 req_ready=1 and wr_ready=1 SHALL hold from the first edge after rst returns high.

Verification
REQ-035 Preload mem[0x40..0x43]=A0..A3, LATENCY=2, request req_addr=0x104 -> beats A0,A1,A2,A3 on cycles 3..6 after acceptance, with rsp_last only on A3.
REQ-036 Issue wr_en to 0x108 with data 0xDEADBEEF during a burst, then request block 0x100 -> write drains in IDLE, req_ready=0 until drained, then beat 2 = 0xDEADBEEF.
REQ-037 Issue three writes during one burst -> wr_ready=0 on the third until IDLE, then all three land in order, with the last write to a duplicate address winning.
REQ-038 In IDLE with an empty buffer, assert wr_en to 0x200 with data 0x12345678 and req_valid for 0x200 on the same edge -> beat 0 = 0x12345678.
REQ-039 Assert rst low at the second beat -> rsp_valid=0 asynchronously; after release, a new request completes normally with four beats.
REQ-040 Run with LATENCY=0 -> first beat on the cycle after acceptance; request req_addr=0xFF0 -> beats read words 0x3FC..0x3FF with no wrap error.
